track_renderer: RTL and testbench

TRACK_RENDERER -- requirements
Module: track_renderer

---
 rtl/track_renderer.sv | 247 ++++++++++++++++++++++++
 tb/tb_track_renderer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/track_renderer.sv
`default_nettype none
// ============================================================================
// Module      : track_renderer
// Description : Three-lane runner game renderer. Two-stage pixel pipeline
//               (hit flags, then colour) plus per-frame game state: player
//               lane, falling obstacle, LFSR lane picker and RUN/CRASH FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module track_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int LANE_W   = 160,
    parameter int PLAYER_Y = 400,
    parameter int SPRITE   = 32,
    parameter int SPEED    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] hdata,
    input  logic [11:0] vdata,
    input  logic        valid,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        lane_left,
    input  logic        lane_right,
    input  logic        restart,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_tick,
    output logic        collision
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CRASH = 1'b1
    } state_t;

    // 13-bit working width so that "+ SPRITE" and "+ 1" never wrap.
    localparam logic [12:0] c_H_ACTIVE = 13'(H_ACTIVE);
    localparam logic [12:0] c_V_ACTIVE = 13'(V_ACTIVE);
    localparam logic [12:0] c_LANE_W   = 13'(LANE_W);
    localparam logic [12:0] c_LANE_W2  = 13'(2 * LANE_W);
    localparam logic [12:0] c_OFS      = 13'((LANE_W - SPRITE) / 2);
    localparam logic [12:0] c_PLAYER_Y = 13'(PLAYER_Y);
    localparam logic [12:0] c_SPRITE   = 13'(SPRITE);
    localparam logic [12:0] c_SPEED    = 13'(SPEED);

    localparam logic [1:0]  c_PEND_NONE  = 2'd0;
    localparam logic [1:0]  c_PEND_LEFT  = 2'd1;
    localparam logic [1:0]  c_PEND_RIGHT = 2'd2;

    localparam logic [11:0] c_RGB_BLACK  = 12'h000;
    localparam logic [11:0] c_RGB_PLAYER = 12'hFF0;
    localparam logic [11:0] c_RGB_CRASH  = 12'hF00;
    localparam logic [11:0] c_RGB_OBST   = 12'h0F0;
    localparam logic [11:0] c_RGB_LINE   = 12'hFFF;
    localparam logic [11:0] c_RGB_TRACK  = 12'h222;

    // Left edge of the sprite centred in a lane.
    function automatic logic [12:0] lane_x(input logic [1:0] lane);
        case (lane)
            2'd0:    lane_x = c_OFS;
            2'd1:    lane_x = c_LANE_W + c_OFS;
            default: lane_x = c_LANE_W2 + c_OFS;
        endcase
    endfunction

    // Pipeline registers
    logic        r_valid_q,      w_valid_d;
    logic        r_hsync1_q,     r_vsync1_q;
    logic        r_blank1_q,     w_blank_d;
    logic        r_blank2_q;
    logic        r_player_hit_q, w_player_hit_d;
    logic        r_obst_hit_q,   w_obst_hit_d;
    logic        r_line_hit_q,   w_line_hit_d;
    logic [11:0] r_rgb_q,        w_rgb_d;
    logic        r_hsync2_q,     r_vsync2_q;
    logic        r_frame_tick_q;

    // Game state registers
    logic [1:0]  r_lane_q,       w_lane_d;
    logic [11:0] r_obst_y_q,     w_obst_y_d;
    logic [1:0]  r_obst_lane_q,  w_obst_lane_d;
    logic [1:0]  r_pend_q,       w_pend_d;
    state_t      r_state_q,      w_state_d;
    logic [7:0]  r_lfsr_q,       w_lfsr_d;

    logic [12:0] w_h, w_v, w_px0, w_ox0, w_oy, w_obst_sum;
    logic        w_tick, w_overlap, w_req_any;
    logic [1:0]  w_req_new;

    // Stage-1 hit flags from the incoming pixel and stage-2 colour priority
    always_comb begin
        w_h            = {1'b0, hdata};
        w_v            = {1'b0, vdata};
        w_px0          = lane_x(r_lane_q);
        w_ox0          = lane_x(r_obst_lane_q);
        w_oy           = {1'b0, r_obst_y_q};
        w_valid_d      = valid && (w_h < c_H_ACTIVE);
        w_blank_d      = (w_v >= c_V_ACTIVE);
        w_player_hit_d = (w_h >= w_px0) && (w_h < w_px0 + c_SPRITE) &&
                         (w_v >= c_PLAYER_Y) && (w_v < c_PLAYER_Y + c_SPRITE);
        w_obst_hit_d   = (w_h >= w_ox0) && (w_h < w_ox0 + c_SPRITE) &&
                         (w_v >= w_oy) && (w_v < w_oy + c_SPRITE);
        // |h - n*LANE_W| < 2 is the closed range [n*LANE_W-1, n*LANE_W+1]
        w_line_hit_d   = ((w_h + 13'd1 >= c_LANE_W)  && (w_h <= c_LANE_W + 13'd1)) ||
                         ((w_h + 13'd1 >= c_LANE_W2) && (w_h <= c_LANE_W2 + 13'd1));

        w_rgb_d = c_RGB_TRACK;
        if (!r_valid_q) begin
            w_rgb_d = c_RGB_BLACK;
        end else if (r_player_hit_q) begin
            w_rgb_d = (r_state_q == ST_CRASH) ? c_RGB_CRASH : c_RGB_PLAYER;
        end else if (r_obst_hit_q) begin
            w_rgb_d = c_RGB_OBST;
        end else if (r_line_hit_q) begin
            w_rgb_d = c_RGB_LINE;
        end
    end

    // Two-stage pixel pipeline; syncs reset to their inactive-high level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q      <= 1'b0;
            r_hsync1_q     <= 1'b1;
            r_vsync1_q     <= 1'b1;
            r_blank1_q     <= 1'b0;
            r_blank2_q     <= 1'b0;
            r_player_hit_q <= 1'b0;
            r_obst_hit_q   <= 1'b0;
            r_line_hit_q   <= 1'b0;
            r_rgb_q        <= c_RGB_BLACK;
            r_hsync2_q     <= 1'b1;
            r_vsync2_q     <= 1'b1;
            r_frame_tick_q <= 1'b0;
        end else begin
            r_valid_q      <= w_valid_d;
            r_hsync1_q     <= hsync_in;
            r_vsync1_q     <= vsync_in;
            r_blank1_q     <= w_blank_d;
            r_blank2_q     <= r_blank1_q;
            r_player_hit_q <= w_player_hit_d;
            r_obst_hit_q   <= w_obst_hit_d;
            r_line_hit_q   <= w_line_hit_d;
            r_rgb_q        <= w_rgb_d;
            r_hsync2_q     <= r_hsync1_q;
            r_vsync2_q     <= r_vsync1_q;
            r_frame_tick_q <= w_tick;
        end
    end

    // Game next-state: lane requests, obstacle motion, RUN/CRASH transitions
    always_comb begin
        w_tick     = r_blank1_q && !r_blank2_q;
        w_lfsr_d   = {r_lfsr_q[6:0], r_lfsr_q[7] ^ r_lfsr_q[5] ^ r_lfsr_q[4] ^ r_lfsr_q[3]};
        w_obst_sum = {1'b0, r_obst_y_q} + c_SPEED;
        w_overlap  = (r_obst_lane_q == r_lane_q) &&
                     ({1'b0, r_obst_y_q} + c_SPRITE > c_PLAYER_Y) &&
                     ({1'b0, r_obst_y_q} < c_PLAYER_Y + c_SPRITE);

        // Simultaneous left+right cancels whatever was pending
        w_req_any = lane_left || lane_right;
        w_req_new = c_PEND_NONE;
        if (lane_left && !lane_right) begin
            w_req_new = c_PEND_LEFT;
        end else if (lane_right && !lane_left) begin
            w_req_new = c_PEND_RIGHT;
        end

        w_lane_d      = r_lane_q;
        w_obst_y_d    = r_obst_y_q;
        w_obst_lane_d = r_obst_lane_q;
        w_pend_d      = r_pend_q;
        w_state_d     = r_state_q;

        case (r_state_q)
            ST_RUN: begin
                w_pend_d = w_req_any ? w_req_new : r_pend_q;
                if (w_tick) begin
                    if (w_overlap) begin
                        // Freeze the scene exactly as it was when the hit happened
                        w_state_d = ST_CRASH;
                        w_pend_d  = c_PEND_NONE;
                    end else begin
                        if (r_pend_q == c_PEND_LEFT && r_lane_q != 2'd0) begin
                            w_lane_d = r_lane_q - 2'd1;
                        end else if (r_pend_q == c_PEND_RIGHT && r_lane_q != 2'd2) begin
                            w_lane_d = r_lane_q + 2'd1;
                        end
                        // A request arriving on the tick itself waits for the next frame
                        w_pend_d = w_req_new;
                        if (w_obst_sum >= c_V_ACTIVE) begin
                            w_obst_y_d    = 12'd0;
                            w_obst_lane_d = 2'(r_lfsr_q % 8'd3);
                        end else begin
                            w_obst_y_d = w_obst_sum[11:0];
                        end
                    end
                end
            end
            ST_CRASH: begin
                w_pend_d = c_PEND_NONE;
                if (restart) begin
                    w_state_d     = ST_RUN;
                    w_obst_y_d    = 12'd0;
                    w_obst_lane_d = 2'd0;
                    w_lane_d      = 2'd1;
                end
            end
            default: begin
                w_state_d = ST_RUN;
            end
        endcase
    end

    // Game state registers and LFSR
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_q      <= 2'd1;
            r_obst_y_q    <= 12'd0;
            r_obst_lane_q <= 2'd0;
            r_pend_q      <= c_PEND_NONE;
            r_state_q     <= ST_RUN;
            r_lfsr_q      <= 8'hA5;
        end else begin
            r_lane_q      <= w_lane_d;
            r_obst_y_q    <= w_obst_y_d;
            r_obst_lane_q <= w_obst_lane_d;
            r_pend_q      <= w_pend_d;
            r_state_q     <= w_state_d;
            r_lfsr_q      <= w_lfsr_d;
        end
    end

    assign hsync_out  = r_hsync2_q;
    assign vsync_out  = r_vsync2_q;
    assign vga_r      = r_rgb_q[11:8];
    assign vga_g      = r_rgb_q[7:4];
    assign vga_b      = r_rgb_q[3:0];
    assign frame_tick = r_frame_tick_q;
    assign collision  = (r_state_q == ST_CRASH);

endmodule
`default_nettype wire

// File: tb/tb_track_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_track_renderer
// Description : Scoreboard bench for track_renderer. The driver pushes the
//               expected colour/sync/frame_tick of every cycle it drives; a
//               monitor pops and compares two cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_track_renderer;

    localparam int c_V_ACTIVE = 480;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] hdata = '0;
    logic [11:0] vdata = '0;
    logic        valid = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        lane_left = 1'b0;
    logic        lane_right = 1'b0;
    logic        restart = 1'b0;
    logic        hsync_out, vsync_out, frame_tick, collision;
    logic [3:0]  vga_r, vga_g, vga_b;

    always #5 clk = ~clk;

    track_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .hdata      (hdata),
        .vdata      (vdata),
        .valid      (valid),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .lane_left  (lane_left),
        .lane_right (lane_right),
        .restart    (restart),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .frame_tick (frame_tick),
        .collision  (collision)
    );

    typedef struct packed {
        logic [31:0] due;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        ft;
    } exp_t;

    exp_t  sbq[$];
    string nameq[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    int    lfsr_at_tick = 0;
    logic [7:0] m_lfsr = 8'h00;

    // Cycle counter and reference LFSR (x^8+x^6+x^5+x^4+1)
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= rst ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // Monitor: compare the DUT output against the expectation due this cycle
    always @(negedge clk) begin : mon
        exp_t        e;
        string       nm;
        logic [11:0] got;
        if (sbq.size() > 0 && int'(sbq[0].due) <= cyc) begin
            e   = sbq.pop_front();
            nm  = nameq.pop_front();
            got = {vga_r, vga_g, vga_b};
            n_vec++;
            if (int'(e.due) != cyc || got !== e.rgb || hsync_out !== e.hs ||
                vsync_out !== e.vs || frame_tick !== e.ft) begin
                n_bad++;
                $display("FAIL %s: got rgb=%h hs=%b vs=%b ft=%b (cyc %0d), expected rgb=%h hs=%b vs=%b ft=%b (cyc %0d)",
                         nm, got, hsync_out, vsync_out, frame_tick, cyc,
                         e.rgb, e.hs, e.vs, e.ft, int'(e.due));
            end
        end
    end

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what should appear two cycles later
    task automatic drive(input logic [11:0] h, input logic [11:0] v, input logic vld,
                         input logic hs, input logic vs, input logic ll, input logic lr,
                         input logic rs, input logic [11:0] exp_rgb, input logic exp_ft,
                         input string name);
        exp_t e;
        hdata = h; vdata = v; valid = vld; hsync_in = hs; vsync_in = vs;
        lane_left = ll; lane_right = lr; restart = rs;
        e.due = 32'(cyc + 2); e.rgb = exp_rgb; e.hs = hs; e.vs = vs; e.ft = exp_ft;
        sbq.push_back(e);
        nameq.push_back(name);
        @(posedge clk); #1;
    endtask

    task automatic pix(input int h, input int v, input logic [11:0] exp_rgb, input string name);
        drive(12'(h), 12'(v), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_rgb, 1'b0, name);
    endtask

    task automatic idle(input logic ll, input logic lr, input logic rs);
        drive(12'd0, 12'd0, 1'b0, 1'b1, 1'b1, ll, lr, rs, 12'h000, 1'b0, "idle");
    endtask

    // Two blank lines then one idle; rs2 raises restart on the tick edge itself
    task automatic frame(input logic rs2);
        drive(12'd0, 12'(c_V_ACTIVE), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, "blank_rise");
        lfsr_at_tick = int'(m_lfsr);
        drive(12'd0, 12'(c_V_ACTIVE), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rs2, 12'h000, 1'b0, "blank_hold");
        idle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1; valid = 1'b0; hdata = '0; vdata = '0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        lane_left = 1'b0; lane_right = 1'b0; restart = 1'b0;
        sbq.delete();
        nameq.delete();
        @(posedge clk); #1;
        chk({name, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
        chk({name, "_hsync"}, {11'd0, hsync_out}, 12'd1);
        chk({name, "_vsync"}, {11'd0, vsync_out}, 12'd1);
        chk({name, "_collision"}, {11'd0, collision}, 12'd0);
        chk({name, "_frame_tick"}, {11'd0, frame_tick}, 12'd0);
        rst = 1'b0;
    endtask

    // Player moves to lane 0 and waits for the lane-0 obstacle to hit it
    task automatic run_to_crash(input string name);
        do_reset(name);
        idle(1'b1, 1'b0, 1'b0);
        repeat (93) frame(1'b0);
        chk({name, "_pre_collision"}, {11'd0, collision}, 12'd0);
        pix(80, 372, 12'h0F0, "obst_at_372");
        pix(80, 410, 12'hFF0, "player_lane0");
        frame(1'b0);
        chk({name, "_collision"}, {11'd0, collision}, 12'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int l;
        @(posedge clk); #1;
        do_reset("por");

        // Pipeline latency, sync delay, lane-divider edges
        drive(12'd100, 12'd50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h222, 1'b0, "track_222");
        drive(12'd100, 12'd50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, "invalid_000");
        drive(12'd160, 12'd50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF, 1'b0, "line1_centre");
        pix(158, 50, 12'h222, "line1_minus2");
        pix(159, 50, 12'hFFF, "line1_minus1");
        pix(161, 50, 12'hFFF, "line1_plus1");
        pix(162, 50, 12'h222, "line1_plus2");
        pix(321, 50, 12'hFFF, "line2_plus1");
        pix(322, 50, 12'h222, "line2_plus2");

        // Player rectangle in lane 1 and obstacle in lane 0 at the top
        pix(240, 410, 12'hFF0, "player_mid");
        pix(224, 400, 12'hFF0, "player_topleft");
        pix(255, 431, 12'hFF0, "player_botright");
        pix(223, 410, 12'h222, "player_left_out");
        pix(256, 410, 12'h222, "player_right_out");
        pix(240, 399, 12'h222, "player_above");
        pix(240, 432, 12'h222, "player_below");
        pix(64, 0, 12'h0F0, "obst_topleft");
        pix(95, 31, 12'h0F0, "obst_botright");
        pix(80, 32, 12'h222, "obst_below");
        pix(63, 10, 12'h222, "obst_left_out");
        pix(96, 10, 12'h222, "obst_right_out");

        // Lane requests wait for the frame tick, saturate, cancel, overwrite
        idle(1'b0, 1'b1, 1'b0);
        pix(240, 410, 12'hFF0, "lane_held_before_tick");
        pix(400, 410, 12'h222, "lane2_empty_before_tick");
        frame(1'b0);
        pix(400, 410, 12'hFF0, "lane_right_applied");
        pix(240, 410, 12'h222, "lane1_vacated");
        idle(1'b0, 1'b1, 1'b0);
        frame(1'b0);
        pix(400, 410, 12'hFF0, "lane_right_saturated");
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        frame(1'b0);
        pix(400, 410, 12'hFF0, "lane_both_cancel");
        idle(1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        frame(1'b0);
        pix(240, 410, 12'hFF0, "lane_overwrite_left");
        pix(400, 410, 12'h222, "lane2_vacated");
        pix(80, 16, 12'h0F0, "obst_after_4_ticks");
        pix(80, 15, 12'h222, "obst_above_after_4");

        // Obstacle wraps to the top in an LFSR-chosen lane
        do_reset("rst_wrap");
        idle(1'b0, 1'b1, 1'b0);
        repeat (119) frame(1'b0);
        pix(80, 476, 12'h0F0, "obst_at_476");
        pix(80, 475, 12'h222, "obst_above_476");
        frame(1'b0);
        l = lfsr_at_tick % 3;
        pix(l * 160 + 80, 0, 12'h0F0, "obst_wrapped_lane");
        pix(((l + 1) % 3) * 160 + 80, 0, 12'h222, "obst_wrapped_other_lane");
        pix(80, 476, 12'h222, "obst_left_bottom");

        // Crash: red player, frozen scene, requests ignored, then restart
        run_to_crash("rst_crash1");
        pix(80, 410, 12'hF00, "crash_player_red");
        idle(1'b0, 1'b1, 1'b0);
        repeat (3) frame(1'b0);
        chk("crash_still_set", {11'd0, collision}, 12'd1);
        pix(80, 372, 12'h0F0, "crash_obst_frozen");
        pix(80, 371, 12'h222, "crash_obst_frozen_above");
        pix(80, 410, 12'hF00, "crash_lane_frozen");
        idle(1'b0, 1'b0, 1'b1);
        chk("restart_clears_collision", {11'd0, collision}, 12'd0);
        pix(240, 410, 12'hFF0, "restart_lane1");
        pix(80, 0, 12'h0F0, "restart_obst_top");
        pix(80, 32, 12'h222, "restart_obst_below");
        frame(1'b0);
        idle(1'b0, 1'b0, 1'b1);
        pix(80, 35, 12'h0F0, "restart_in_run_ignored");
        chk("run_restart_no_collision", {11'd0, collision}, 12'd0);

        // Restart landing on the frame tick wins over the obstacle advance
        run_to_crash("rst_crash2");
        frame(1'b1);
        chk("restart_on_tick_collision", {11'd0, collision}, 12'd0);
        pix(80, 33, 12'h222, "restart_on_tick_no_advance");
        pix(80, 0, 12'h0F0, "restart_on_tick_obst_top");
        pix(240, 410, 12'hFF0, "restart_on_tick_lane1");

        // Reset while crashed overrides an in-flight red pixel
        run_to_crash("rst_crash3");
        pix(80, 410, 12'hF00, "inflight_red");
        do_reset("rst_midop");
        pix(240, 410, 12'hFF0, "post_reset_lane1");
        pix(80, 410, 12'h222, "post_reset_lane0_empty");

        repeat (4) @(posedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
